// File: rtl/accel_pkg.sv
// Shared types and constants for the sign-magnitude accelerator datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accel_pkg;

    // Magnitude width used by the neuron update datapath.
    localparam int SM_NUMWIDTH = 16;

    // A sign-magnitude number: bit SM_SIGN_BIT is the sign (1 = negative).
    localparam int SM_SIGN_BIT = SM_NUMWIDTH;
    typedef logic [SM_NUMWIDTH:0] sm_num_t;

    // Largest representable magnitude, used as the saturation value.
    localparam logic [SM_NUMWIDTH-1:0] SM_MAX_MAG = '1;

    // Output register occupancy.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/just_add.sv
// Raw sign-magnitude adder: returns an unsaturated, unnormalized sum.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b      - sign-magnitude operands (bit NW is the sign)
//        raw_mag   - NW+1 bit magnitude, bit NW is the carry of a same-sign add
//        raw_sign  - sign of the result (may be 1 for a zero magnitude)
module just_add #(
    parameter int NW = 16
) (
    input  logic [NW:0] a,
    input  logic [NW:0] b,
    output logic [NW:0] raw_mag,
    output logic        raw_sign
);

    logic [NW-1:0] am;
    logic [NW-1:0] bm;

    assign am = a[NW-1:0];
    assign bm = b[NW-1:0];

    always_comb begin
        raw_mag  = '0;
        raw_sign = 1'b0;
        if (a[NW] == b[NW]) begin
            raw_mag  = {1'b0, am} + {1'b0, bm};
            raw_sign = a[NW];
        end else if (am >= bm) begin
            // Larger magnitude wins the sign; equal magnitudes land here.
            raw_mag  = {1'b0, am - bm};
            raw_sign = a[NW];
        end else begin
            raw_mag  = {1'b0, bm - am};
            raw_sign = b[NW];
        end
    end

endmodule

// File: rtl/sm_add_arbiter.sv
// Round-robin share of one saturating sign-magnitude adder among NREQ requesters.
// Latency: 1 cycle from req handshake to rsp_valid; throughput 1 result/cycle.
// Backpressure: single result register; a grant is issued only when it is empty or being drained.
// Ports: req_valid/req_ready/req_a/req_b - per-requester operand pairs (flattened, slice i = requester i)
//        rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_sat - registered, ID-tagged result
//        sat_clr/sat_cnt - debug count of saturating transfers (sticks at 0xFFFF)
module sm_add_arbiter
    import accel_pkg::*;
#(
    parameter int NUMWIDTH = SM_NUMWIDTH,
    parameter int NREQ     = 4,
    parameter int IDW      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*(NUMWIDTH+1)-1:0] req_a,
    input  logic [NREQ*(NUMWIDTH+1)-1:0] req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [IDW-1:0]               rsp_id,
    output logic [NUMWIDTH:0]            rsp_sum,
    output logic                         rsp_sat,
    input  logic                         sat_clr,
    output logic [15:0]                  sat_cnt
);

    localparam int W = NUMWIDTH + 1;

    out_state_t    state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] idx;
    logic           grant_vld;
    logic           accept;
    logic           transfer;

    logic [NUMWIDTH:0]   op_a, op_b;
    logic [NUMWIDTH:0]   raw_mag;
    logic                raw_sign;
    logic                sat;
    logic [NUMWIDTH-1:0] res_mag;
    logic                res_sign;

    // Search downward so the last hit written is the first valid at or after rr_ptr.
    // NREQ is a power of two, so the IDW-bit add wraps modulo NREQ for free.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = rr_ptr + IDW'(k);
            if (req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = (state == OUT_EMPTY) || rsp_ready;
        transfer  = accept && grant_vld;
        req_ready = '0;
        if (transfer) begin
            req_ready[grant] = 1'b1;
        end
        case (state)
            OUT_EMPTY: if (transfer) state_nxt = OUT_FULL;
            OUT_FULL:  if (!transfer && rsp_ready) state_nxt = OUT_EMPTY;
            default:   state_nxt = OUT_EMPTY;
        endcase
    end

    assign rsp_valid = (state == OUT_FULL);

    assign op_a = req_a[int'(grant) * W +: W];
    assign op_b = req_b[int'(grant) * W +: W];

    just_add #(.NW(NUMWIDTH)) u_add (
        .a        (op_a),
        .b        (op_b),
        .raw_mag  (raw_mag),
        .raw_sign (raw_sign)
    );

    // Only a same-sign add can set the top bit, so it is the overflow flag.
    // A zero result is forced positive so -0 never leaves the block.
    assign sat      = raw_mag[NUMWIDTH];
    assign res_mag  = sat ? '1 : raw_mag[NUMWIDTH-1:0];
    assign res_sign = (res_mag == '0) ? 1'b0 : raw_sign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id  <= '0;
            rsp_sum <= '0;
            rsp_sat <= 1'b0;
            rr_ptr  <= '0;
        end else if (transfer) begin
            rsp_id  <= grant;
            rsp_sum <= {res_sign, res_mag};
            rsp_sat <= sat;
            rr_ptr  <= grant + 1'b1;
        end
    end

    // A clear coinciding with a saturating transfer still records that event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= (transfer && sat) ? 16'd1 : 16'd0;
        end else if (transfer && sat && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sm_add_arbiter.sv
module tb_sm_add_arbiter;
    import accel_pkg::*;

    localparam int NW   = 16;
    localparam int W    = NW + 1;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [NW:0]       rsp_sum;
    logic              rsp_sat;
    logic              sat_clr;
    logic [15:0]       sat_cnt;

    int checks = 0;
    int errors = 0;

    sm_add_arbiter #(.NUMWIDTH(NW), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_sat   (rsp_sat),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Protocol monitor on the quiet edge: a requester may only drop valid after its
    // handshake, and the arbiter may never assert more than one ready.
    logic [NREQ-1:0] pv = '0;
    logic [NREQ-1:0] pr = '0;
    always @(negedge clk) begin
        if (rst_n && |(pv & ~pr & ~req_valid)) begin
            errors++;
            $display("FAIL protocol valid dropped before ready prev=%0h now=%0h", pv, req_valid);
        end
        checks++;
        if ($countones(req_ready) > 1) begin
            errors++;
            $display("FAIL req_ready_onehot actual=%0h required=at most one bit", req_ready);
        end
        pv = req_valid;
        pr = req_ready;
    end

    typedef struct {
        int          id;
        logic [NW:0] a;
        logic [NW:0] b;
        logic        clr;
        logic [NW:0] sum;
        logic        sat;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[11];

    logic [NREQ-1:0] one;
    logic [NW:0]     rr_sum[4];
    logic            rr_sat[4];

    task automatic set_req(input int id, input logic [NW:0] a, input logic [NW:0] b);
        req_a = '0;
        req_b = '0;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid = one << id;
    endtask

    initial begin
        one = 1;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1; sat_clr = 1'b0;

        //             id  a                    b                    clr   sum                 sat   cnt
        vecs[0]  = '{0, {1'b0,16'd3},       {1'b0,16'd5},       1'b0, {1'b0,16'd8},       1'b0, 16'd0};
        vecs[1]  = '{2, {1'b1,16'd100},     {1'b0,16'd40},      1'b0, {1'b1,16'd60},      1'b0, 16'd0};
        vecs[2]  = '{2, {1'b0,16'd7},       {1'b1,16'd7},       1'b0, {1'b0,16'd0},       1'b0, 16'd0};
        vecs[3]  = '{2, {1'b1,16'd0},       {1'b1,16'd0},       1'b0, {1'b0,16'd0},       1'b0, 16'd0};
        vecs[4]  = '{1, {1'b0,16'h8000},    {1'b0,16'h8000},    1'b0, {1'b0,16'hFFFF},    1'b1, 16'd1};
        vecs[5]  = '{3, {1'b1,16'h8000},    {1'b1,16'h8000},    1'b1, {1'b1,16'hFFFF},    1'b1, 16'd1};
        vecs[6]  = '{0, {1'b0,16'hFFFF},    {1'b1,16'd1},       1'b0, {1'b0,16'hFFFE},    1'b0, 16'd1};
        vecs[7]  = '{1, {1'b1,16'd5},       {1'b0,16'd9},       1'b0, {1'b0,16'd4},       1'b0, 16'd1};
        vecs[8]  = '{3, {1'b0,16'd0},       {1'b1,16'h10},      1'b0, {1'b1,16'h10},      1'b0, 16'd1};
        vecs[9]  = '{0, {1'b0,16'h7FFF},    {1'b0,16'h8000},    1'b0, {1'b0,SM_MAX_MAG},  1'b0, 16'd1};
        vecs[10] = '{3, {1'b0,16'd1},       {1'b0,16'd1},       1'b1, {1'b0,16'd2},       1'b0, 16'd0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id",    rsp_id,    0);
        chk("reset_rsp_sum",   rsp_sum,   0);
        chk("reset_rsp_sat",   rsp_sat,   0);
        chk("reset_sat_cnt",   sat_cnt,   0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-requester arithmetic vectors.
        foreach (vecs[i]) begin
            set_req(vecs[i].id, vecs[i].a, vecs[i].b);
            sat_clr = vecs[i].clr;
            @(negedge clk);
            chk($sformatf("v%0d_req_ready", i), req_ready, one << vecs[i].id);
            @(posedge clk); #1;
            sat_clr = 1'b0;
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("v%0d_rsp_id", i),    rsp_id,    vecs[i].id);
            chk($sformatf("v%0d_rsp_sum", i),   rsp_sum,   vecs[i].sum);
            chk($sformatf("v%0d_rsp_sat", i),   rsp_sat,   vecs[i].sat);
            chk($sformatf("v%0d_sat_cnt", i),   sat_cnt,   vecs[i].cnt);
        end

        // Round robin with all requesters held valid; requester 2 overflows.
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = {1'b0, 16'(i + 1)};
            req_b[i*W +: W] = {1'b0, 16'd10};
            rr_sum[i] = {1'b0, 16'(i + 11)};
            rr_sat[i] = 1'b0;
        end
        req_a[2*W +: W] = {1'b0, 16'hFFFF};
        req_b[2*W +: W] = {1'b0, 16'h8000};
        rr_sum[2] = {1'b0, 16'hFFFF};
        rr_sat[2] = 1'b1;
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_req_ready", k), req_ready, one << (k % NREQ));
            @(posedge clk); #1;
            chk($sformatf("rr%0d_rsp_id", k),  rsp_id,  k % NREQ);
            chk($sformatf("rr%0d_rsp_sum", k), rsp_sum, rr_sum[k % NREQ]);
            chk($sformatf("rr%0d_rsp_sat", k), rsp_sat, rr_sat[k % NREQ]);
        end
        chk("rr_sat_cnt", sat_cnt, 1);

        // Backpressure: result for requester 0 must hold.
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_req_ready", k), req_ready, 0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d_rsp_valid", k), rsp_valid, 1);
            chk($sformatf("bp%0d_rsp_id", k),    rsp_id,    0);
            chk($sformatf("bp%0d_rsp_sum", k),   rsp_sum,   rr_sum[0]);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_req_ready", req_ready, 4'b0010);
        @(posedge clk); #1;
        chk("bp_release_rsp_id",  rsp_id,  1);
        chk("bp_release_rsp_sum", rsp_sum, rr_sum[1]);
        @(posedge clk); #1;
        chk("pre_rst_rsp_id",  rsp_id,  2);
        chk("pre_rst_sat_cnt", sat_cnt, 2);

        // Asynchronous reset while full; all requesters still waiting.
        rsp_ready = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", rsp_valid, 0);
        chk("async_rst_rsp_sum",   rsp_sum,   0);
        chk("async_rst_rsp_sat",   rsp_sat,   0);
        chk("async_rst_sat_cnt",   sat_cnt,   0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_req_ready", k), req_ready, one << k);
            @(posedge clk); #1;
            chk($sformatf("post_rst%0d_rsp_id", k), rsp_id, k);
            req_valid[k] = 1'b0;
        end

        // Drain with nobody requesting.
        @(negedge clk);
        chk("idle_req_ready", req_ready, 0);
        @(posedge clk); #1;
        chk("drain_rsp_valid", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm_add_arbiter.md
Name: sm_add_arbiter

Overview:
- Round-robin arbiter that shares one sign-magnitude adder among NREQ requesters in the Izhikevich update datapath, e.g. the v/u update units and the synaptic current accumulators.
- Each requester presents two sign-magnitude operands. The block grants one requester per cycle, performs the add with saturation and -0 normalization, and returns a registered, ID-tagged result on a shared response bus with backpressure.
- Also counts saturation events for debug.

Parameters:
- NUMWIDTH, 16, magnitude bits; every operand and result is NUMWIDTH+1 bits, with bit NUMWIDTH as the sign (1 = negative).
- NREQ, 4, number of requesters; power of two, minimum 2.
- IDW, 2, requester ID width; equals log2(NREQ).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  bit i: requester i has an operand pair.
- req_ready  out  NREQ  bit i: requester i's pair is accepted this cycle.
- req_a  in  NREQ*(NUMWIDTH+1)  flattened operand A; slice i belongs to requester i.
- req_b  in  NREQ*(NUMWIDTH+1)  flattened operand B.
- rsp_valid  out  1  result register holds valid data.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  ID of the requester that owns the result.
- rsp_sum  out  NUMWIDTH+1  sign-magnitude sum.
- rsp_sat  out  1  result was saturated.
- sat_clr  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  16  saturation event counter.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_sat=0, sat_cnt=0, rr_ptr=0, FSM=OUT_EMPTY.
- Output FSM states: OUT_EMPTY and OUT_FULL. rsp_valid=1 exactly when the FSM is in OUT_FULL.
- accept = (state==OUT_EMPTY) || rsp_ready.
- Arbitration:
  - grant goes to the first i with req_valid[i], searching from rr_ptr upward modulo NREQ.
  - req_ready[i] = accept && grant==i. It is combinational from req_valid, and at most one bit is ever set.
- Requester rule: req_valid and operands stay stable until req_ready. Dropping req_valid before ready is a protocol violation, and the bench asserts on it.
- Transfer: when a req_valid[i]&&req_ready[i] handshake occurs, the next edge does all of the following:
  - rsp_sum, rsp_sat and rsp_id load.
  - rr_ptr becomes (i+1) mod NREQ.
  - state becomes OUT_FULL.
- rr_ptr is unchanged in any cycle with no transfer.
- FSM transitions:
  - OUT_EMPTY→OUT_FULL on a transfer.
  - OUT_FULL→OUT_EMPTY when rsp_ready is high and there is no transfer.
  - OUT_FULL→OUT_FULL on rsp_ready plus a transfer (back-to-back, throughput 1/cycle).
  - OUT_FULL holds with outputs frozen while rsp_ready=0.
- Latency: 1 cycle from handshake to rsp_valid.
- Arithmetic, with am/bm = magnitudes and as/bs = signs:
  - Same sign: the NUMWIDTH+1-bit sum am+bm is formed. If its carry bit is set, rsp_sum={as, all ones} and rsp_sat=1. Otherwise rsp_sum={as, am+bm}.
  - Opposite sign: the larger magnitude minus the smaller, carrying the larger operand's sign. Equal magnitudes give +0.
  - Any zero-magnitude result gets sign 0; -0 is never output.
  - -0 as an input is accepted and treated as 0.
- sat_cnt increments on each transfer with rsp_sat=1 and saturates at 0xFFFF.
  - sat_clr alone sets sat_cnt to 0.
  - sat_clr together with a saturating transfer sets sat_cnt to 1.
- Reset mid-operation: any pending result is discarded. An unaccepted requester keeps req_valid and is served after reset.
- No requester valid: req_ready=0 and the FSM drains normally.

Decomposition:
- Shared package (accel_pkg) holds:
  - NUMWIDTH default.
  - sm_num_t, a typedef of NUMWIDTH+1 bits.
  - SM_SIGN_BIT.
  - SM_MAX_MAG constant.
- Sub-module: the team's existing sign-magnitude adder just_add, instantiated once on the muxed operands.
- Carry detection, saturation and -0 normalization sit in this block around just_add.
- Arbiter, FSM and counter are inline; no further sub-modules.

Test Plan:
- Requester 0 only, A=+3, B=+5, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum={0,8}, rsp_sat=0.
- Requester 2, A={1,100}, B={0,40} -> rsp_sum={1,60}. Then A={0,7}, B={1,7} -> rsp_sum={0,0}. Then A={1,0}, B={1,0} -> rsp_sum={0,0}.
- A={0,0x8000}, B={0,0x8000} -> rsp_sum={0,0xFFFF}, rsp_sat=1, sat_cnt=1.
- Same overflow with sign 1, with sat_clr pulsed in the same cycle -> rsp_sum={1,0xFFFF}, sat_cnt=1.
- All 4 req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 on consecutive cycles, exactly one req_ready bit set per cycle.
- Output full, then rsp_ready=0 for 3 cycles with all req_valid high -> rsp_sum and rsp_id frozen, req_ready=0. On rsp_ready=1, the next ID in rotation is granted in the same cycle.
- rst_n pulsed low while in OUT_FULL -> asynchronously rsp_valid=0, rr_ptr=0, sat_cnt=0. First grant after release goes to the lowest valid ID.
